// File: rtl/fft_corr_pkg.sv
// Shared types and helpers for the FFT correlator datapath.
// Complex samples are packed {im, re}, two's complement.
package fft_corr_pkg;

  localparam int COMP_W = 16;

  typedef struct packed {
    logic signed [COMP_W-1:0] im;
    logic signed [COMP_W-1:0] re;
  } complex_t;

  typedef struct packed {
    complex_t data;
    logic     sat;
  } conj_t;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DRAIN} state_t;

  // The most negative imaginary value has no positive twin, so it clips.
  function automatic conj_t conj_sat(input complex_t x);
    conj_t r;
    r.data.re = x.re;
    if (x.im == {1'b1, {(COMP_W-1){1'b0}}}) begin
      r.data.im = {1'b0, {(COMP_W-1){1'b1}}};
      r.sat     = 1'b1;
    end else begin
      r.data.im = -x.im;
      r.sat     = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/ref_ram.sv
// Simple dual-port reference store: one write port, one registered read port.
module ref_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              aclk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ref_spectrum_buffer.sv
// Captures one conjugated reference FFT frame and replays it frame after frame,
// with a frame-aligned reload that never emits a partial frame.
module ref_spectrum_buffer
  import fft_corr_pkg::*;
#(
  parameter int LOG2N_MAX = 12
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [3:0]          fft_log2,
  input  logic                reload,
  input  logic [2*COMP_W-1:0] s_ref_tdata,
  input  logic                s_ref_tvalid,
  output logic                s_ref_tready,
  input  logic                s_ref_tlast,
  output logic [2*COMP_W-1:0] m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                ref_loaded,
  output logic                frame_err,
  output logic                conj_sat,
  output logic [15:0]         play_frames
);

  localparam int AW = LOG2N_MAX;
  localparam int DW = 2*COMP_W;

  state_t          state_reg, state_next;
  logic [3:0]      log2_clamped;
  logic [AW-1:0]   n_last_in, n_last_reg, wr_addr_reg, wr_addr, rd_addr_reg;
  logic            s_ref_tready_reg, ref_loaded_reg, frame_err_reg, conj_sat_reg;
  logic [15:0]     play_frames_reg;
  logic            rd_valid_reg, rd_last_reg;
  logic [DW-1:0]   ram_rd_data, out_data_reg, skid_data_reg;
  logic            out_valid_reg, out_last_reg, skid_valid_reg, skid_last_reg;
  conj_t           conj_in;
  logic            load_beat, load_final, load_short;
  logic            pop, last_pop, flush, last_in_pipe, rd_issue, rd_last;
  logic [1:0]      fill;

  always_comb begin
    if (fft_log2 < 4'd3) log2_clamped = 4'd3;
    else if (int'(fft_log2) > LOG2N_MAX) log2_clamped = 4'(LOG2N_MAX);
    else log2_clamped = fft_log2;
  end

  assign n_last_in  = AW'((32'd1 << log2_clamped) - 32'd1);
  assign conj_in    = fft_corr_pkg::conj_sat(complex_t'(s_ref_tdata));
  assign load_beat  = s_ref_tvalid && s_ref_tready_reg;
  assign wr_addr    = (state_reg == IDLE) ? '0 : wr_addr_reg;
  assign load_final = load_beat && (wr_addr == ((state_reg == IDLE) ? n_last_in : n_last_reg));
  assign load_short = load_beat && s_ref_tlast && !load_final;

  assign pop      = out_valid_reg && m_tready;
  assign last_pop = pop && out_last_reg;
  assign last_in_pipe = (rd_valid_reg && rd_last_reg) || (out_valid_reg && out_last_reg)
                     || (skid_valid_reg && skid_last_reg);
  assign fill     = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(rd_valid_reg);
  assign rd_last  = (rd_addr_reg == n_last_reg);
  // Fetch only while the skid can absorb the in-flight read; in DRAIN stop once the closing tlast is fetched.
  assign rd_issue = ((state_reg == PLAY) || (state_reg == DRAIN && !last_in_pipe))
                 && (fill <= 2'd1 + 2'(pop));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, LOAD: begin
        if (load_final)      state_next = PLAY;
        else if (load_short) state_next = IDLE;
        else if (load_beat)  state_next = LOAD;
      end
      PLAY:    if (reload) state_next = last_pop ? IDLE : DRAIN;
      DRAIN:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign flush = ((state_reg == PLAY) || (state_reg == DRAIN)) && (state_next == IDLE);

  always_ff @(posedge aclk) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  ref_ram #(.DATA_W(DW), .ADDR_W(AW)) u_ram (
    .aclk    (aclk),
    .wr_en   (load_beat),
    .wr_addr (wr_addr),
    .wr_data (conj_in.data),
    .rd_en   (rd_issue),
    .rd_addr (rd_addr_reg),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_ref_tready_reg <= 1'b0;
      n_last_reg       <= '0;
      wr_addr_reg      <= '0;
      rd_addr_reg      <= '0;
      ref_loaded_reg   <= 1'b0;
      frame_err_reg    <= 1'b0;
      conj_sat_reg     <= 1'b0;
      play_frames_reg  <= '0;
      rd_valid_reg     <= 1'b0;
      rd_last_reg      <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_last_reg     <= 1'b0;
      out_data_reg     <= '0;
      skid_valid_reg   <= 1'b0;
      skid_last_reg    <= 1'b0;
      skid_data_reg    <= '0;
    end else begin
      s_ref_tready_reg <= (state_next == IDLE) || (state_next == LOAD);

      if (load_beat) begin
        wr_addr_reg <= wr_addr + AW'(1);
        if (state_reg == IDLE) begin
          n_last_reg    <= n_last_in;
          frame_err_reg <= 1'b0;
          conj_sat_reg  <= conj_in.sat;
        end else if (conj_in.sat) begin
          conj_sat_reg <= 1'b1;
        end
        if (load_short || (load_final && !s_ref_tlast)) frame_err_reg <= 1'b1;
      end

      if (load_final)                  ref_loaded_reg <= 1'b1;
      else if (load_short || flush)    ref_loaded_reg <= 1'b0;

      if (last_pop) play_frames_reg <= play_frames_reg + 16'(1);

      rd_valid_reg <= rd_issue && !flush;
      if (rd_issue) begin
        rd_last_reg <= rd_last;
        rd_addr_reg <= rd_last ? '0 : rd_addr_reg + AW'(1);
      end
      if (load_final) rd_addr_reg <= '0;

      // Two-entry output queue: out_* is the AXI register, skid_* catches the read landing during a stall.
      if (flush) begin
        out_valid_reg  <= 1'b0;
        out_last_reg   <= 1'b0;
        skid_valid_reg <= 1'b0;
      end else if (!out_valid_reg || pop) begin
        out_valid_reg <= skid_valid_reg || rd_valid_reg;
        if (skid_valid_reg) begin
          out_data_reg <= skid_data_reg;
          out_last_reg <= skid_last_reg;
        end else if (rd_valid_reg) begin
          out_data_reg <= ram_rd_data;
          out_last_reg <= rd_last_reg;
        end
        skid_valid_reg <= skid_valid_reg && rd_valid_reg;
        if (rd_valid_reg) begin
          skid_data_reg <= ram_rd_data;
          skid_last_reg <= rd_last_reg;
        end
      end else if (rd_valid_reg) begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= ram_rd_data;
        skid_last_reg  <= rd_last_reg;
      end
    end
  end

  assign s_ref_tready = s_ref_tready_reg;
  assign m_tdata      = out_data_reg;
  assign m_tvalid     = out_valid_reg;
  assign m_tlast      = out_last_reg;
  assign ref_loaded   = ref_loaded_reg;
  assign frame_err    = frame_err_reg;
  assign conj_sat     = conj_sat_reg;
  assign play_frames  = play_frames_reg;

endmodule

// File: tb/tb_ref_spectrum_buffer.sv
// Directed/randomized bench for ref_spectrum_buffer against a frame-level model
// of the stored conjugated reference and the expected replay sequence.
module tb_ref_spectrum_buffer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  fft_log2;
  logic        reload;
  logic [31:0] s_ref_tdata;
  logic        s_ref_tvalid, s_ref_tready, s_ref_tlast;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        ref_loaded, frame_err, conj_sat;
  logic [15:0] play_frames;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_mem [0:4095];
  int          exp_n = 8;
  int          exp_idx = 0;
  logic [15:0] exp_frames = '0;
  logic        exp_loaded = 1'b0;
  logic        exp_err = 1'b0;
  logic        exp_sat = 1'b0;

  always #5 aclk = ~aclk;

  ref_spectrum_buffer dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .fft_log2     (fft_log2),
    .reload       (reload),
    .s_ref_tdata  (s_ref_tdata),
    .s_ref_tvalid (s_ref_tvalid),
    .s_ref_tready (s_ref_tready),
    .s_ref_tlast  (s_ref_tlast),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .ref_loaded   (ref_loaded),
    .frame_err    (frame_err),
    .conj_sat     (conj_sat),
    .play_frames  (play_frames)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] conj_model(input logic [31:0] d);
    int re, im;
    re = int'($signed(d[15:0]));
    im = -int'($signed(d[31:16]));
    if (im > 32767) im = 32767;
    return {im[15:0], re[15:0]};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tready"}, s_ref_tready, 0);
    check({tag, "_tvalid"}, m_tvalid, 0);
    check({tag, "_tlast"}, m_tlast, 0);
    check({tag, "_tdata"}, m_tdata, 0);
    check({tag, "_loaded"}, ref_loaded, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_csat"}, conj_sat, 0);
    check({tag, "_frames"}, play_frames, 0);
  endtask

  // Drives nbeats accepted beats; tlast on beat tlast_at (-1: never); im forced to -32768 on sat_at.
  task automatic load_frame(input int lg, input int nbeats, input int tlast_at,
                            input int sat_at, input bit ramp);
    int n, k, cyc;
    logic [15:0] re, im;
    logic sat;
    n = 1 << lg; k = 0; cyc = 0; sat = 1'b0;
    m_tready = 1'b0;
    fft_log2 = lg[3:0];
    while (k < nbeats && cyc < 1000) begin
      if (ramp || $urandom_range(3) != 0) begin
        re = ramp ? 16'(k) : 16'($urandom_range(65535));
        im = ramp ? 16'(k) : 16'($urandom_range(65535));
        if (k == sat_at) im = 16'h8000;
        s_ref_tdata  = {im, re};
        s_ref_tvalid = 1'b1;
        s_ref_tlast  = (k == tlast_at);
        check("load_tready", s_ref_tready, 1);
      end else begin
        s_ref_tvalid = 1'b0;
      end
      if (!ramp) reload = 1'($urandom_range(1));
      if (s_ref_tvalid && s_ref_tready) begin
        exp_mem[k] = conj_model(s_ref_tdata);
        if (s_ref_tdata[31:16] == 16'h8000) sat = 1'b1;
        k++;
      end
      tick();
      cyc++;
      if (!ramp && k >= 1) fft_log2 = 4'($urandom_range(15));
    end
    s_ref_tvalid = 1'b0;
    s_ref_tlast  = 1'b0;
    reload       = 1'b0;
    check("load_done", k, nbeats);
    exp_sat = sat;
    if (tlast_at >= 0 && tlast_at < n-1) begin
      exp_loaded = 1'b0;
      exp_err    = 1'b1;
    end else begin
      exp_loaded = 1'b1;
      exp_err    = (tlast_at != n-1);
      exp_n      = n;
      exp_idx    = 0;
    end
  endtask

  task automatic check_latency();
    check("tready_after_last", s_ref_tready, 0);
    check("lat_edge0", m_tvalid, 0);
    tick();
    check("lat_edge1", m_tvalid, 0);
    tick();
    check("lat_edge2", m_tvalid, 1);
  endtask

  task automatic collect(input int nbeats, input int rdy_pct);
    int got, cyc;
    bit started, stalled;
    logic [31:0] held_d;
    logic held_l;
    got = 0; cyc = 0; started = 0; stalled = 0; held_d = '0; held_l = 1'b0;
    while (got < nbeats && cyc < 4000) begin
      if (started) check("valid_hold", m_tvalid, 1);
      if (stalled) begin
        check("stall_data", m_tdata, held_d);
        check("stall_last", m_tlast, held_l);
      end
      if (m_tvalid) started = 1;
      m_tready = ($urandom_range(99) < rdy_pct);
      stalled  = m_tvalid && !m_tready;
      held_d   = m_tdata;
      held_l   = m_tlast;
      if (m_tvalid && m_tready) begin
        check("replay_data", m_tdata, exp_mem[exp_idx]);
        check("replay_last", m_tlast, exp_idx == exp_n-1);
        if (exp_idx == exp_n-1) begin
          exp_idx = 0;
          exp_frames++;
        end else begin
          exp_idx++;
        end
        got++;
      end
      tick();
      cyc++;
    end
    m_tready = 1'b0;
    check("collect_done", got, nbeats);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_loaded"}, ref_loaded, exp_loaded);
    check({tag, "_ferr"}, frame_err, exp_err);
    check({tag, "_csat"}, conj_sat, exp_sat);
    check({tag, "_frames"}, play_frames, exp_frames);
  endtask

  initial begin
    int cyc;
    aresetn = 1'b0; fft_log2 = 4'd3; reload = 1'b0;
    s_ref_tdata = '0; s_ref_tvalid = 1'b0; s_ref_tlast = 1'b0; m_tready = 1'b0;
    tick();
    tick();
    check_reset_values("rst");
    aresetn = 1'b1;
    tick();
    check("rst_release_tready", s_ref_tready, 1);

    // Ramp reference, N=8, full-rate replay of three frames
    load_frame(3, 8, 7, -1, 1);
    check_latency();
    collect(24, 100);
    check("ramp_frames", play_frames, 16'd3);
    check_flags("ramp");

    // Reload pulsed after index 3: rest of the frame still emitted, then IDLE
    collect(4, 100);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    collect(4, 100);
    exp_loaded = 1'b0;
    check("drain_tvalid", m_tvalid, 0);
    check("drain_tready", s_ref_tready, 1);
    check_flags("drain");
    repeat (5) tick();
    check("drain_quiet", m_tvalid, 0);

    // N=16 random reference with a saturating sample, 50% back-pressure
    load_frame(4, 16, 15, 2, 0);
    check("sat_mem2", exp_mem[2][31:16], 16'h7fff);
    check_latency();
    collect(40, 50);
    check_flags("n16");

    // Reload coinciding with the final tlast handshake
    collect((exp_n - 1 - exp_idx + exp_n) % exp_n, 100);
    cyc = 0;
    while (!m_tvalid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("coinc_last", m_tlast, 1);
    check("coinc_data", m_tdata, exp_mem[exp_idx]);
    m_tready = 1'b1;
    reload   = 1'b1;
    tick();
    m_tready = 1'b0;
    reload   = 1'b0;
    exp_frames++;
    exp_idx    = 0;
    exp_loaded = 1'b0;
    check("coinc_tvalid", m_tvalid, 0);
    check("coinc_tready", s_ref_tready, 1);
    check_flags("coinc");

    // Short frame: tlast on beat 4 of 8
    load_frame(3, 5, 4, -1, 0);
    check_flags("short");
    check("short_tready", s_ref_tready, 1);
    repeat (8) tick();
    check("short_quiet", m_tvalid, 0);

    // Final beat without tlast: loads, flags error, replays
    load_frame(3, 8, -1, -1, 0);
    check_latency();
    collect(16, 70);
    check_flags("notlast");

    // One-cycle reset in the middle of replay
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    aresetn = 1'b0;
    tick();
    check_reset_values("midrst");
    aresetn = 1'b1;
    exp_frames = '0; exp_loaded = 1'b0; exp_err = 1'b0; exp_sat = 1'b0;
    repeat (10) tick();
    check("midrst_quiet", m_tvalid, 0);
    check_flags("midrst");

    load_frame(5, 32, 31, 7, 0);
    check_latency();
    collect(70, 50);
    check_flags("n32");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
